// File: rtl/param_mux_1_if.sv
// Bus bundle for param_mux_1: a qualified data/select request and the registered pick result.
interface param_mux_1_if #(
    parameter int N     = 16,
    parameter int SEL_W = 4
);
    logic [N-1:0]     in;
    logic [SEL_W-1:0] sel;
    logic             in_valid;
    logic             y;
    logic             out_valid;
    logic             err;
    logic [SEL_W-1:0] sel_q;

    modport master (
        output in, sel, in_valid,
        input  y, out_valid, err, sel_q
    );

    modport slave (
        input  in, sel, in_valid,
        output y, out_valid, err, sel_q
    );
endinterface

// File: rtl/param_mux_1.sv
// N-to-1 single-bit mux with one registered output stage and an out-of-range select flag.
module param_mux_1 #(
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    param_mux_1_if.slave  bus
);
    localparam int LEGS = 1 << SEL_W;
    localparam logic [SEL_W:0] N_LIMIT = N[SEL_W:0];

    if (SEL_W != $clog2(N) || N < 2) begin : g_bad_params
        $error("param_mux_1: SEL_W must equal $clog2(N) and N must be >= 2");
    end

    // Pad the data to every encodable select code so unused codes read a hard 0.
    logic [LEGS-1:0] in_ext;
    for (genvar gi = 0; gi < LEGS; gi++) begin : g_leg
        if (gi < N) begin : g_used
            assign in_ext[gi] = bus.in[gi];
        end else begin : g_unused
            assign in_ext[gi] = 1'b0;
        end
    end

    logic             pick_d;
    logic             err_d;
    logic [SEL_W-1:0] sel_d;

    assign err_d  = ({1'b0, bus.sel} >= N_LIMIT);
    assign pick_d = err_d ? 1'b0 : in_ext[bus.sel];
    assign sel_d  = bus.sel;

    logic             y_q;
    logic             err_q;
    logic             valid_q;
    logic [SEL_W-1:0] sel_reg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q       <= 1'b0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            sel_reg_q <= '0;
        end else if (bus.in_valid) begin
            y_q       <= pick_d;
            err_q     <= err_d;
            valid_q   <= 1'b1;
            sel_reg_q <= sel_d;
        end else begin
            valid_q   <= 1'b0;
        end
    end

    assign bus.y         = y_q;
    assign bus.err       = err_q;
    assign bus.out_valid = valid_q;
    assign bus.sel_q     = sel_reg_q;
endmodule

// File: tb/tb_param_mux_1.sv
// Scoreboard bench for param_mux_1 at N=16, N=12 (non power of two) and N=2.
module tb_param_mux_1;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    typedef struct {
        logic y;
        logic err;
        int   sel;
    } exp_t;

    exp_t q16[$];
    exp_t q12[$];
    exp_t q2[$];

    param_mux_1_if #(.N(16), .SEL_W(4)) if16 ();
    param_mux_1_if #(.N(12), .SEL_W(4)) if12 ();
    param_mux_1_if #(.N(2),  .SEL_W(1)) if2  ();

    param_mux_1 #(.N(16), .SEL_W(4)) u_mux16 (.clk(clk), .rst(rst), .bus(if16.slave));
    param_mux_1 #(.N(12), .SEL_W(4)) u_mux12 (.clk(clk), .rst(rst), .bus(if12.slave));
    param_mux_1 #(.N(2),  .SEL_W(1)) u_mux2  (.clk(clk), .rst(rst), .bus(if2.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endfunction

    // Monitor: pop one expected transaction whenever a DUT presents out_valid.
    always @(negedge clk) begin
        exp_t e;
        if (if16.out_valid) begin
            if (q16.size() == 0) chk("n16_unexpected_valid", 1, 0);
            else begin
                e = q16.pop_front();
                $display("n16 txn: sel_q=%0d y=%0b err=%0b", if16.sel_q, if16.y, if16.err);
                chk("n16_y", int'(if16.y), int'(e.y));
                chk("n16_err", int'(if16.err), int'(e.err));
                chk("n16_sel_q", int'(if16.sel_q), e.sel);
            end
        end
        if (if12.out_valid) begin
            if (q12.size() == 0) chk("n12_unexpected_valid", 1, 0);
            else begin
                e = q12.pop_front();
                $display("n12 txn: sel_q=%0d y=%0b err=%0b", if12.sel_q, if12.y, if12.err);
                chk("n12_y", int'(if12.y), int'(e.y));
                chk("n12_err", int'(if12.err), int'(e.err));
                chk("n12_sel_q", int'(if12.sel_q), e.sel);
            end
        end
        if (if2.out_valid) begin
            if (q2.size() == 0) chk("n2_unexpected_valid", 1, 0);
            else begin
                e = q2.pop_front();
                $display("n2 txn: sel_q=%0d y=%0b err=%0b", if2.sel_q, if2.y, if2.err);
                chk("n2_y", int'(if2.y), int'(e.y));
                chk("n2_err", int'(if2.err), int'(e.err));
                chk("n2_sel_q", int'(if2.sel_q), e.sel);
            end
        end
    end

    // Drive one cycle of stimulus on instance 'which' and record the expected result.
    task automatic drv(input int which, input int d, input int s, input logic v,
                       input logic ey, input logic ee);
        exp_t e;
        @(negedge clk);
        e.y   = ey;
        e.err = ee;
        e.sel = s;
        case (which)
            16: begin
                if16.in = d[15:0]; if16.sel = s[3:0]; if16.in_valid = v;
                if (v) q16.push_back(e);
            end
            12: begin
                if12.in = d[11:0]; if12.sel = s[3:0]; if12.in_valid = v;
                if (v) q12.push_back(e);
            end
            default: begin
                if2.in = d[1:0]; if2.sel = s[0]; if2.in_valid = v;
                if (v) q2.push_back(e);
            end
        endcase
    endtask

    logic sweep_exp [16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                            1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        if16.in = '0; if16.sel = '0; if16.in_valid = 1'b0;
        if12.in = '0; if12.sel = '0; if12.in_valid = 1'b0;
        if2.in  = '0; if2.sel  = '0; if2.in_valid  = 1'b0;

        #3;
        chk("reset_y", int'(if16.y), 0);
        chk("reset_err", int'(if16.err), 0);
        chk("reset_sel_q", int'(if16.sel_q), 0);
        chk("reset_out_valid", int'(if16.out_valid), 0);
        chk("reset_n12_out_valid", int'(if12.out_valid), 0);
        chk("reset_n2_out_valid", int'(if2.out_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 16; s++) drv(16, 32'h1AA9, s, 1'b1, sweep_exp[s], 1'b0);

        drv(16, 32'h1AA9, 3, 1'b1, 1'b1, 1'b0);
        drv(16, 32'h0000, 1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_y", int'(if16.y), 1);
            chk("hold_sel_q", int'(if16.sel_q), 3);
            chk("hold_out_valid", int'(if16.out_valid), 0);
        end

        // Asynchronous reset between edges while y=1 is held.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_y", int'(if16.y), 0);
        chk("async_rst_err", int'(if16.err), 0);
        chk("async_rst_sel_q", int'(if16.sel_q), 0);
        chk("async_rst_out_valid", int'(if16.out_valid), 0);

        // Reset and valid together: reset must win across an edge.
        @(negedge clk);
        if16.in = 16'h0001; if16.sel = 4'd0; if16.in_valid = 1'b1;
        @(negedge clk);
        chk("rst_vs_valid_y", int'(if16.y), 0);
        chk("rst_vs_valid_out_valid", int'(if16.out_valid), 0);
        rst = 1'b0;
        e.y = 1'b1; e.err = 1'b0; e.sel = 0;
        q16.push_back(e);
        drv(16, 32'h0000, 0, 1'b0, 1'b0, 1'b0);

        drv(12, 32'hFFF, 13, 1'b1, 1'b0, 1'b1);
        drv(12, 32'hFFF, 11, 1'b1, 1'b1, 1'b0);
        drv(12, 32'hFFF, 15, 1'b1, 1'b0, 1'b1);
        drv(12, 32'h801, 0, 1'b1, 1'b1, 1'b0);
        drv(12, 32'h801, 12, 1'b1, 1'b0, 1'b1);
        drv(12, 32'h000, 0, 1'b0, 1'b0, 1'b0);

        drv(2, 32'h2, 0, 1'b1, 1'b0, 1'b0);
        drv(2, 32'h2, 1, 1'b1, 1'b1, 1'b0);
        drv(2, 32'h1, 0, 1'b1, 1'b1, 1'b0);
        drv(2, 32'h1, 1, 1'b1, 1'b0, 1'b0);
        drv(2, 32'h0, 0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("n16_all_outputs_seen", q16.size(), 0);
        chk("n12_all_outputs_seen", q12.size(), 0);
        chk("n2_all_outputs_seen", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
